xc20xx_cfg_loader: RTL
======================

# xc20xx_cfg_loader

- Serial configuration loader for an XC20XX-series CLB array.
- Parses a bit-serial bitstream: preamble, length count, framed configuration data, postamble.
- Validates the framing and emits one parallel configuration frame per write strobe.
- Sits between the device configuration pin and the per-column frame registers that supply each CLB's function-generator INIT, input-select, Y_OUT and storage-element (S_IN/CLK_IN/CLK_POL/MODE/R_IN) settings.

## Interface

Parameters:
- FRAME_BITS, 46: data bits per configuration frame.
- NUM_FRAMES, 160: frames in a full bitstream.
- LEN_W, 24: width of the length-count field.

Ports (clock and reset first):
- K  in  1  clock; all state changes on rising edge.
- RESET_N  in  1  reset, asynchronous, active-low.
- DIN  in  1  serial bitstream bit.
- DIN_VALID  in  1  DIN is consumed on this edge when high.
- ABORT  in  1  synchronous restart to IDLE; highest priority.
- FRAME_DATA  out  FRAME_BITS  assembled frame; first received data bit lands in the MSB.
- FRAME_ADDR  out  clog2(NUM_FRAMES)  index of the frame in FRAME_DATA.
- FRAME_WE  out  1  one-cycle write strobe for a validated frame.
- BUSY  out  1  high in every state except IDLE, DONE and ERROR.
- DONE  out  1  configuration complete; sticky.
- ERR  out  1  framing error; sticky.

## Operation

Bitstream format, MSB first:
- Any number of idle 1s.
- Preamble 0010.
- LEN_W-bit length count LEN.
- Filler 1111.
- NUM_FRAMES frames, each: start bit 0, FRAME_BITS data bits, stop bits 111.
- Postamble: don't-care bits up to LEN.

Bit counting:
- BITCNT (LEN_W bits) counts accepted bits.
- The first preamble bit is count 1, so LEN covers the whole stream from preamble through postamble.
- MINLEN = 4 + LEN_W + 4 + NUM_FRAMES*(FRAME_BITS+4).

State machine (advances only on DIN_VALID):
- IDLE: a 4-bit history register matches 0010 → LENGTH, BITCNT=4. Bits are not counted before the match.
- LENGTH: shift LEN_W bits into LEN. After the last bit, if LEN < MINLEN → ERROR, else → FILL.
- FILL: 4 bits, each must be 1, else → ERROR; then → START.
- START: bit must be 0, else → ERROR; then → DATA.
- DATA: shift FRAME_BITS bits into FRAME_DATA (shift-left, new bit into the LSB); then → STOP.
- STOP: 3 bits, each must be 1, else → ERROR.
  - On the third stop bit: FRAME_WE=1 on the next cycle with FRAME_DATA and FRAME_ADDR stable.
  - FRAME_ADDR increments the cycle after the strobe.
  - If this was frame NUM_FRAMES-1 → POST, else → START.
- POST: bits ignored; when BITCNT reaches LEN → DONE.
  - If BITCNT already equals LEN on entry to POST → DONE immediately.
- DONE: BUSY=0, DONE=1. DIN ignored until ABORT or reset.
- ERROR: ERR=1, BUSY=0. No further FRAME_WE. DIN ignored until ABORT or reset.

Rules:
- A corrupt frame (bad start or stop bit) is never strobed.
- FRAME_DATA is not cleared between frames.
- ABORT, any state: next edge → IDLE; clears DONE, ERR, FRAME_ADDR, BITCNT and the history register; FRAME_WE=0. ABORT overrides a coincident DIN_VALID.
- RESET_N low, any time including mid-frame: immediate return to IDLE.

## Timing

- Reset values: FRAME_DATA=0, FRAME_ADDR=0, FRAME_WE=0, BUSY=0, DONE=0, ERR=0; state IDLE.
- One bit consumed per edge with DIN_VALID=1. DIN_VALID=0 stalls all counters and the state, with no timeout.
- FRAME_WE latency: 1 cycle after the edge that accepts the third stop bit. The strobe is never longer than one cycle, even if DIN_VALID stays low.
- BUSY rises 1 cycle after the edge that completes the preamble.
- DONE and ERR assert 1 cycle after the deciding bit.
- ERR also fires if BITCNT reaches LEN before the final frame's STOP completes; it is checked on every accepted bit.
- DONE and ERR are mutually exclusive.

## Test plan

All scenarios use FRAME_BITS=4, NUM_FRAMES=2, LEN_W=24, giving MINLEN=48.

1. Nominal stream: 1111, 0010, LEN=50, 1111, frame 0 0 1010 111, frame 1 0 0101 111, postamble 11 (continuous valid).
   - FRAME_WE pulses twice: ADDR 0 / DATA 4'hA, then ADDR 1 / DATA 4'h5.
   - DONE=1 one cycle after bit 50; ERR=0.
2. Same stream with DIN_VALID toggling 1010….
   - Identical strobes and data.
   - DONE after 50 accepted bits.
   - FRAME_WE still exactly one cycle wide.
3. Frame 1 second stop bit = 0.
   - Only the frame-0 strobe occurs.
   - ERR=1, BUSY=0; DONE never asserts.
4. LEN=47.
   - ERR=1 after the last length bit.
   - No FRAME_WE ever.
5. LEN=48, exact minimum.
   - DONE one cycle after the frame-1 strobe cycle.
   - LEN=49 with only 48 bits sent: DONE stays 0 and BUSY stays 1.
6. Assert ABORT mid-DATA of frame 1, then resend stream 1.
   - BUSY=0 and FRAME_ADDR=0 after ABORT.
   - Resend gives the full scenario-1 result.
   - RESET_N pulsed mid-stream gives the same outcome, with all outputs at reset values immediately.

Source files
------------

// File: rtl/xc20xx_cfg_loader.sv
// Serial configuration loader for an XC20XX CLB array.
// It parses the framed bitstream and strobes out one validated parallel frame at a time.
module xc20xx_cfg_loader #(
  parameter int unsigned FRAME_BITS = 46,
  parameter int unsigned NUM_FRAMES = 160,
  parameter int unsigned LEN_W      = 24
) (
  input  logic                  K,
  input  logic                  RESET_N,
  input  logic                  DIN,
  input  logic                  DIN_VALID,
  input  logic                  ABORT,
  output logic [FRAME_BITS-1:0] FRAME_DATA,
  output logic [((NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1)-1:0] FRAME_ADDR,
  output logic                  FRAME_WE,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  localparam int unsigned AW      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int unsigned MINLEN  = 4 + LEN_W + 4 + NUM_FRAMES * (FRAME_BITS + 4);
  localparam int unsigned CNT_MAX = (LEN_W > FRAME_BITS) ? LEN_W : FRAME_BITS;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LENGTH, S_FILL, S_START, S_DATA, S_STOP, S_POST, S_DONE, S_ERROR
  } state_t;

  state_t                  state, state_n;
  logic [3:0]              hist, hist_n;
  logic [LEN_W-1:0]        bitcnt, bitcnt_n, bitcnt_inc;
  logic [LEN_W-1:0]        len, len_n;
  logic [CW-1:0]           fcnt, fcnt_n;
  logic [FRAME_BITS-1:0]   data_n;
  logic                    we_n;
  logic                    last_frame;

  assign last_frame = (FRAME_ADDR == AW'(NUM_FRAMES - 1));

  // Next-state and datapath decode
  always_comb begin
    state_n    = state;
    hist_n     = hist;
    bitcnt_n   = bitcnt;
    len_n      = len;
    fcnt_n     = fcnt;
    data_n     = FRAME_DATA;
    we_n       = 1'b0;
    bitcnt_inc = bitcnt + LEN_W'(1);

    if (ABORT) begin
      state_n  = S_IDLE;
      hist_n   = 4'hF;
      bitcnt_n = '0;
      fcnt_n   = '0;
    end else if (state == S_POST && bitcnt == len) begin
      state_n = S_DONE;
    end else if (DIN_VALID) begin
      if (state != S_IDLE && state != S_DONE && state != S_ERROR)
        bitcnt_n = bitcnt_inc;
      case (state)
        S_IDLE: begin
          hist_n = {hist[2:0], DIN};
          if (hist_n == 4'b0010) begin
            state_n  = S_LENGTH;
            bitcnt_n = LEN_W'(4);
            fcnt_n   = '0;
          end
        end
        S_LENGTH: begin
          len_n  = {len[LEN_W-2:0], DIN};
          fcnt_n = fcnt + CW'(1);
          if (fcnt == CW'(LEN_W - 1)) begin
            fcnt_n  = '0;
            state_n = (len_n < LEN_W'(MINLEN)) ? S_ERROR : S_FILL;
          end
        end
        S_FILL: begin
          fcnt_n = fcnt + CW'(1);
          if (!DIN) begin
            state_n = S_ERROR;
          end else if (fcnt == CW'(3)) begin
            fcnt_n  = '0;
            state_n = S_START;
          end
        end
        S_START: begin
          fcnt_n  = '0;
          state_n = DIN ? S_ERROR : S_DATA;
        end
        S_DATA: begin
          data_n = {FRAME_DATA[FRAME_BITS-2:0], DIN};
          fcnt_n = fcnt + CW'(1);
          if (fcnt == CW'(FRAME_BITS - 1)) begin
            fcnt_n  = '0;
            state_n = S_STOP;
          end
        end
        S_STOP: begin
          fcnt_n = fcnt + CW'(1);
          if (!DIN) begin
            state_n = S_ERROR;
          end else if (fcnt == CW'(2)) begin
            fcnt_n  = '0;
            we_n    = 1'b1;
            state_n = last_frame ? S_POST : S_START;
          end
        end
        S_POST: begin
          if (bitcnt_inc == len) state_n = S_DONE;
        end
        default: ;
      endcase
      // Running out of length before the last frame closes is a framing error
      if ((state == S_FILL || state == S_START || state == S_DATA || state == S_STOP) &&
          state_n != S_ERROR && state_n != S_POST && bitcnt_inc == len) begin
        state_n = S_ERROR;
        we_n    = 1'b0;
      end
    end
  end

  always_ff @(posedge K or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= S_IDLE;
      hist       <= 4'hF;
      bitcnt     <= '0;
      len        <= '0;
      fcnt       <= '0;
      FRAME_DATA <= '0;
      FRAME_ADDR <= '0;
      FRAME_WE   <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      state      <= state_n;
      hist       <= hist_n;
      bitcnt     <= bitcnt_n;
      len        <= len_n;
      fcnt       <= fcnt_n;
      FRAME_DATA <= data_n;
      FRAME_WE   <= we_n;
      if (ABORT)
        FRAME_ADDR <= '0;
      else if (FRAME_WE)
        FRAME_ADDR <= FRAME_ADDR + AW'(1);
      BUSY <= (state_n != S_IDLE) && (state_n != S_DONE) && (state_n != S_ERROR);
      DONE <= (state_n == S_DONE);
      ERR  <= (state_n == S_ERROR);
    end
  end

endmodule
